// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//
// Purpose:
//   Shares one combinational ALU between two requesters. Grants are
//   round-robin. The winner's opcode and operands are registered onto the ALU
//   inputs and held for one ISSUE cycle. The ALU result and carry are then
//   captured and returned on a single valid/ready response channel, tagged
//   with the requester ID. A saturating counter tracks completed operations.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req{0,1}_valid/ready          request handshake per requester
//   req{0,1}_ctrl/x/y             opcode and operands per requester
//   alu_ctrl/alu_x/alu_y          registered drive to the shared ALU
//   alu_out/alu_carry             combinational ALU result
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_out/rsp_carry      registered response payload
//   op_count                      completed operations, saturating
//   busy                          high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,

  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_carry,

  output logic [CNT_W-1:0]  op_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] countMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] countOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t nextState;

  logic lastServed;
  logic grantId;
  logic acceptAny;
  logic respDone;

  // Round-robin pick. On contention, the requester that was not served last
  // wins. The pointer moves only when a response completes.
  always_comb begin
    grantId = 1'b0;
    if (req0_valid && req1_valid) begin
      grantId = ~lastServed;
    end else if (req1_valid) begin
      grantId = 1'b1;
    end
  end

  // Ready is masked by reset so that nothing looks accepted while reset is
  // held, even though the state register already reads IDLE.
  assign req0_ready = !reset && (state == IDLE) && req0_valid && (grantId == 1'b0);
  assign req1_ready = !reset && (state == IDLE) && req1_valid && (grantId == 1'b1);

  assign acceptAny = req0_ready || req1_ready;
  assign respDone  = (state == RESP) && rsp_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (acceptAny) nextState = ISSUE;
      ISSUE:   nextState = RESP;
      RESP:    if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ALU operand registers. They load only on accept and otherwise hold their
  // last value, so the ALU stays stable through ISSUE and afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ctrl <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
      rsp_id   <= 1'b0;
    end else if (req0_ready) begin
      alu_ctrl <= req0_ctrl;
      alu_x    <= req0_x;
      alu_y    <= req0_y;
      rsp_id   <= 1'b0;
    end else if (req1_ready) begin
      alu_ctrl <= req1_ctrl;
      alu_x    <= req1_x;
      alu_y    <= req1_y;
      rsp_id   <= 1'b1;
    end
  end

  // The response payload is captured at the end of ISSUE and held for as long
  // as the consumer applies backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
    end else if (state == ISSUE) begin
      rsp_valid <= 1'b1;
      rsp_out   <= alu_out;
      rsp_carry <= alu_carry;
    end else if (respDone) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completion bookkeeping. Reset points lastServed at requester 1, so
  // requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastServed <= 1'b1;
      op_count   <= '0;
    end else if (respDone) begin
      lastServed <= rsp_id;
      if (op_count != countMax) begin
        op_count <= op_count + countOne;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//
// Purpose:
//   Directed, self-checking bench for alu_rr_scheduler. It instantiates two
//   copies that share the same stimulus. The main copy uses the default
//   parameters. The second copy uses CNT_W=2 to exercise counter saturation.
//   Each copy drives its own small behavioural ALU.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_ctrl, req1_ctrl;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic       rsp_ready;

  logic        req0_ready, req1_ready;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_x, alu_y, alu_out;
  logic        alu_carry;
  logic        rsp_valid, rsp_id, rsp_carry, busy;
  logic [7:0]  rsp_out;
  logic [15:0] op_count;

  logic       satReq0Ready, satReq1Ready;
  logic [3:0] satAluCtrl;
  logic [7:0] satAluX, satAluY, satAluOut;
  logic       satAluCarry;
  logic       satRspValid, satRspId, satRspCarry, satBusy;
  logic [7:0] satRspOut;
  logic [1:0] satOpCount;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 subtract (carry is the borrow), 2 and, 3 or,
  // 4 xor, anything else gives zero.
  function automatic logic [8:0] aluModel(input logic [3:0] c, input logic [7:0] a,
                                          input logic [7:0] b);
    case (c)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return 9'd0;
    endcase
  endfunction

  assign {alu_carry, alu_out}       = aluModel(alu_ctrl, alu_x, alu_y);
  assign {satAluCarry, satAluOut}   = aluModel(satAluCtrl, satAluX, satAluY);

  alu_rr_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .op_count(op_count), .busy(busy)
  );

  alu_rr_scheduler #(.CNT_W(2)) satDut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(satReq0Ready), .req0_ctrl(req0_ctrl),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(satReq1Ready), .req1_ctrl(req1_ctrl),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_ctrl(satAluCtrl), .alu_x(satAluX), .alu_y(satAluY),
    .alu_out(satAluOut), .alu_carry(satAluCarry),
    .rsp_valid(satRspValid), .rsp_ready(rsp_ready), .rsp_id(satRspId),
    .rsp_out(satRspOut), .rsp_carry(satRspCarry),
    .op_count(satOpCount), .busy(satBusy)
  );

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one requester's channel.
  task automatic applyStimulus(input int id, input logic v, input logic [3:0] c,
                               input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      req0_valid = v; req0_ctrl = c; req0_x = a; req0_y = b;
    end else begin
      req1_valid = v; req1_ctrl = c; req1_x = a; req1_y = b;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [3:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expOut;
    logic       expCarry;
  } vec_t;

  vec_t satVecs[5];

  initial begin
    satVecs[0] = '{0, 4'd0, 8'h05, 8'h04, 8'h09, 1'b0};
    satVecs[1] = '{1, 4'd1, 8'h03, 8'h05, 8'hFE, 1'b1};
    satVecs[2] = '{0, 4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
    satVecs[3] = '{1, 4'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    satVecs[4] = '{0, 4'd4, 8'hAA, 8'hFF, 8'h55, 1'b0};

    // Reset held with both requesters asking.
    reset = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 4'd0, 8'd5, 8'd4);
    applyStimulus(1, 1'b1, 4'd0, 8'd3, 8'd2);
    tick();
    tick();
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_op_count", op_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_x", alu_x, 0);
    checkOutput("rst_rsp_out", rsp_out, 0);
    checkOutput("rst_sat_count", satOpCount, 0);

    // Single request from requester 0: 5 + 4.
    applyStimulus(1, 1'b0, 4'd0, 8'd0, 8'd0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checkOutput("single_req0_ready", req0_ready, 1);
    checkOutput("single_req1_ready", req1_ready, 0);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 8'd5, 8'd4);
    #1;
    checkOutput("issue_busy", busy, 1);
    checkOutput("issue_rsp_valid", rsp_valid, 0);
    checkOutput("issue_alu_x", alu_x, 8'd5);
    checkOutput("issue_alu_y", alu_y, 8'd4);
    tick();
    checkOutput("single_rsp_valid", rsp_valid, 1);
    checkOutput("single_rsp_out", rsp_out, 8'd9);
    checkOutput("single_rsp_carry", rsp_carry, 0);
    checkOutput("single_rsp_id", rsp_id, 0);
    tick();
    checkOutput("single_done_valid", rsp_valid, 0);
    checkOutput("single_done_busy", busy, 0);
    checkOutput("single_op_count", op_count, 1);

    // Contention: after a fresh reset, requester 0 goes first and grants
    // alternate from there.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 4'd0, 8'hFF, 8'h01);
    applyStimulus(1, 1'b1, 4'd0, 8'h03, 8'h02);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr%0d_req0_ready", i), req0_ready, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr%0d_req1_ready", i), req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      tick();
      checkOutput($sformatf("rr%0d_rsp_valid", i), rsp_valid, 1);
      checkOutput($sformatf("rr%0d_rsp_id", i), rsp_id, i % 2);
      checkOutput($sformatf("rr%0d_rsp_out", i), rsp_out, (i % 2 == 0) ? 8'h00 : 8'h05);
      checkOutput($sformatf("rr%0d_rsp_carry", i), rsp_carry, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr%0d_resp_readys", i), {req0_ready, req1_ready}, 0);
      tick();
      checkOutput($sformatf("rr%0d_op_count", i), op_count, i + 1);
    end

    // Backpressure: the response is held for 10 cycles.
    rsp_ready = 1'b0;
    applyStimulus(1, 1'b0, 4'd0, 8'h03, 8'h02);
    applyStimulus(0, 1'b1, 4'd0, 8'h10, 8'h20);
    #1;
    checkOutput("bp_req0_ready", req0_ready, 1);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 8'h10, 8'h20);
    applyStimulus(1, 1'b1, 4'd0, 8'h03, 8'h02);
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
      checkOutput($sformatf("bp%0d_rsp_out", i), rsp_out, 8'h30);
      checkOutput($sformatf("bp%0d_readys", i), {req0_ready, req1_ready}, 0);
      checkOutput($sformatf("bp%0d_busy", i), busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_release_busy", busy, 0);
    checkOutput("bp_release_valid", rsp_valid, 0);
    checkOutput("bp_release_count", op_count, 5);
    checkOutput("bp_release_req1_ready", req1_ready, 1);
    applyStimulus(1, 1'b0, 4'd0, 8'h03, 8'h02);

    // Reset asserted while the operation is in ISSUE.
    applyStimulus(0, 1'b1, 4'd0, 8'h07, 8'h01);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 8'h07, 8'h01);
    checkOutput("rst_issue_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_issue_busy", busy, 0);
    checkOutput("rst_issue_valid", rsp_valid, 0);
    checkOutput("rst_issue_count", op_count, 0);
    checkOutput("rst_issue_alu_x", alu_x, 0);
    tick();
    checkOutput("rst_issue_no_rsp", rsp_valid, 0);

    // Reset asserted while the operation is in RESP.
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 4'd0, 8'h07, 8'h01);
    tick();
    applyStimulus(0, 1'b0, 4'd0, 8'h07, 8'h01);
    tick();
    checkOutput("rst_resp_pre_valid", rsp_valid, 1);
    checkOutput("rst_resp_pre_out", rsp_out, 8'h08);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_resp_valid", rsp_valid, 0);
    checkOutput("rst_resp_busy", busy, 0);
    checkOutput("rst_resp_count", op_count, 0);
    checkOutput("rst_resp_out", rsp_out, 0);
    tick();
    checkOutput("rst_resp_no_rsp", rsp_valid, 0);

    // Five ops through both copies, with mixed opcodes and requesters. The
    // CNT_W=2 counter must stop at 3.
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(satVecs[i].id, 1'b1, satVecs[i].c, satVecs[i].a, satVecs[i].b);
      #1;
      checkOutput($sformatf("sat%0d_ready", i),
                  (satVecs[i].id == 0) ? req0_ready : req1_ready, 1);
      tick();
      applyStimulus(satVecs[i].id, 1'b0, 4'd0, 8'd0, 8'd0);
      tick();
      checkOutput($sformatf("sat%0d_rsp_id", i), rsp_id, satVecs[i].id);
      checkOutput($sformatf("sat%0d_rsp_out", i), rsp_out, satVecs[i].expOut);
      checkOutput($sformatf("sat%0d_rsp_carry", i), rsp_carry, satVecs[i].expCarry);
      tick();
      checkOutput($sformatf("sat%0d_sat_count", i), satOpCount, (i < 3) ? i + 1 : 3);
      checkOutput($sformatf("sat%0d_op_count", i), op_count, i + 1);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
